// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable down-counter with pause, abort and optional auto-reload.
//   A start in IDLE loads load_val and counts down one per clock.
//   done pulses for one cycle on the edge where the count reaches 0.
//   At count 0, the next edge either reloads (auto_reload=1) or returns to IDLE.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   load_val     start value, sampled when a start is accepted
//   start        start request, honoured only while ready=1
//   pause        level, freezes the count while high
//   abort        ends the run immediately, without a done pulse
//   auto_reload  level, sampled when the count sits at 0
//   count        registered count value
//   busy         high in RUN or PAUSED
//   ready        high in IDLE (always ~busy)
//   done         registered one-cycle terminal pulse
module countdown_timer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             ready,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] reload;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= ZERO;
            reload <= ZERO;
            done   <= 1'b0;
        end else if (abort) begin
            // Abort beats start, pause and terminal. The reload value is kept.
            state <= IDLE;
            count <= ZERO;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (load_val == ZERO) begin
                            // A zero-length run only produces the done pulse.
                            done  <= 1'b1;
                            count <= ZERO;
                        end else begin
                            count  <= load_val;
                            reload <= load_val;
                            state  <= pause ? PAUSED : RUN;
                        end
                    end
                end
                RUN, PAUSED: begin
                    if (pause) begin
                        // Pause also blocks the 1->0 step, so done stays low.
                        state <= PAUSED;
                        done  <= 1'b0;
                    end else begin
                        // Leaving PAUSED counts on the same edge.
                        state <= RUN;
                        done  <= (count == ONE);
                        if (count != ZERO)
                            count <= count - ONE;
                        else if (auto_reload)
                            count <= reload;
                        else
                            state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= ZERO;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign ready = ~busy;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer.
// A behavioural model steps once per rising edge. All DUT outputs are compared
// against that model on every falling edge after the first reset edge.
// Literal checks pin the model to hand-computed sequences.
module tb_countdown_timer;

    localparam int WIDTH = 6;

    logic             clk = 1'b0;
    logic             rst, start, pause, abort, auto_reload;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             busy, ready, done;

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .load_val(load_val), .start(start),
        .pause(pause), .abort(abort), .auto_reload(auto_reload),
        .count(count), .busy(busy), .ready(ready), .done(done)
    );

    always #5 clk = ~clk;

    // model state
    int m_count, m_reload;
    bit m_busy, m_done;
    bit m_valid = 0;

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behaviour from the rules: reset > abort > start (idle) > pause > count/terminal.
    task automatic model_step();
        if (rst) begin
            m_count = 0; m_busy = 0; m_reload = 0; m_done = 0; m_valid = 1;
        end else if (abort) begin
            m_count = 0; m_busy = 0; m_done = 0;
        end else if (!m_busy) begin
            m_done = start && (load_val == 0);
            if (start && load_val != 0) begin
                m_count = int'(load_val); m_reload = int'(load_val); m_busy = 1;
            end
        end else if (pause) begin
            m_done = 0;
        end else begin
            m_done = (m_count == 1);
            if (m_count > 0) m_count = m_count - 1;
            else if (auto_reload) m_count = m_reload;
            else m_busy = 0;
        end
    endtask

    // One clock: model update at the rising edge, full compare at the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (m_valid) begin
            chk("count", int'(count), m_count);
            chk("busy",  int'(busy),  int'(m_busy));
            chk("ready", int'(ready), int'(!m_busy));
            chk("done",  int'(done),  int'(m_done));
        end
    endtask

    task automatic drive(input bit r, input bit s, input int lv, input bit p,
                         input bit a, input bit ar);
        rst = r; start = s; load_val = WIDTH'(lv); pause = p; abort = a; auto_reload = ar;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        // reset for 2 cycles
        cyc(); cyc();
        chk("rst_count", int'(count), 0);
        chk("rst_ready", int'(ready), 1);
        chk("rst_done",  int'(done),  0);

        // load 5: expected count sequence 5,4,3,2,1,0
        drive(0, 1, 5, 0, 0, 0); cyc();
        chk("l5_first", int'(count), 5);
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 4; k >= 0; k--) begin
            cyc();
            chk("l5_seq", int'(count), k);
            chk("l5_done", int'(done), (k == 0) ? 1 : 0);
        end
        cyc();
        chk("l5_idle_ready", int'(ready), 1);
        chk("l5_idle_done", int'(done), 0);

        // auto-reload with load 3: expected count sequence 3,2,1,0,3,2,1,0
        drive(0, 1, 3, 0, 0, 1); cyc();
        drive(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 7; k++) begin
            cyc();
            chk("ar_seq", int'(count), 3 - ((k + 1) % 4));
            chk("ar_busy", int'(busy), 1);
        end
        chk("ar_done2", int'(done), 1);
        drive(0, 0, 0, 0, 1, 0); cyc();
        chk("ar_abort", int'(busy), 0);

        // load 4 with pause for 3 cycles at count 2; done is expected 7 edges after start
        drive(0, 1, 4, 0, 0, 0); cyc();
        drive(0, 0, 0, 0, 0, 0); cyc(); cyc();
        chk("p_at2", int'(count), 2);
        drive(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("p_hold", int'(count), 2);
        end
        drive(0, 0, 0, 0, 0, 0); cyc();
        chk("p_resume", int'(count), 1);
        cyc();
        chk("p_done", int'(done), 1);
        cyc();

        // load 10, then abort at count 6
        drive(0, 1, 10, 0, 0, 0); cyc();
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc();
        chk("ab_at6", int'(count), 6);
        drive(0, 1, 20, 1, 1, 0); cyc();   // abort beats start and pause
        chk("ab_count", int'(count), 0);
        chk("ab_done", int'(done), 0);
        chk("ab_ready", int'(ready), 1);
        // a start with load 0 is expected to give one done pulse and count 0
        drive(0, 1, 0, 0, 0, 0); cyc();
        chk("z_done", int'(done), 1);
        chk("z_count", int'(count), 0);
        drive(0, 0, 0, 0, 0, 0); cyc();
        chk("z_done_off", int'(done), 0);

        // a start with load 9 while busy at count 4 is expected to be ignored
        drive(0, 1, 7, 0, 0, 0); cyc();
        drive(0, 0, 0, 0, 0, 0); cyc(); cyc(); cyc();
        chk("ig_at4", int'(count), 4);
        drive(0, 1, 9, 0, 0, 0); cyc();
        chk("ig_count", int'(count), 3);
        drive(0, 0, 0, 0, 0, 0); cyc(); cyc(); cyc();
        chk("ig_done", int'(done), 1);
        cyc();

        // pause at count 1 is expected to hold the count with no done
        drive(0, 1, 2, 0, 0, 0); cyc();
        drive(0, 0, 0, 0, 0, 0); cyc();
        drive(0, 0, 0, 1, 0, 0); cyc();
        chk("p1_hold", int'(count), 1);
        chk("p1_nodone", int'(done), 0);
        drive(0, 0, 0, 0, 0, 0); cyc();
        chk("p1_done", int'(done), 1);
        cyc();

        // full-scale load of 63
        drive(0, 1, 63, 0, 0, 0); cyc();
        chk("max_load", int'(count), 63);
        drive(0, 0, 0, 0, 0, 0); cyc();
        chk("max_dec", int'(count), 62);

        // reset mid-run at count 7, with pause and start also high
        drive(0, 0, 0, 0, 1, 0); cyc();
        drive(0, 1, 9, 0, 0, 0); cyc();
        drive(0, 0, 0, 0, 0, 0); cyc(); cyc();
        chk("rr_at7", int'(count), 7);
        drive(1, 1, 9, 1, 0, 0); cyc();
        chk("rr_count", int'(count), 0);
        chk("rr_busy", int'(busy), 0);
        chk("rr_ready", int'(ready), 1);
        chk("rr_done", int'(done), 0);
        drive(0, 0, 0, 0, 0, 0); cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 6: bit width of load value and count.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port load_val  input  WIDTH  start value, sampled only when a start is accepted.
REQ-005 SHALL have port start  input  1  start request, accepted only when ready=1.
REQ-006 SHALL have port pause  input  1  level; freezes count while high.
REQ-007 SHALL have port abort  input  1  terminates the run without done.
REQ-008 SHALL have port auto_reload  input  1  level; sampled at terminal count.
REQ-009 SHALL have port count  output  WIDTH  current registered count value.
REQ-010 SHALL have port busy  output  1  high in RUN or PAUSED.
REQ-011 SHALL have port ready  output  1  high in IDLE; equals ~busy.
REQ-012 SHALL have port done  output  1  registered one-cycle pulse at terminal count.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and PAUSED.
REQ-014 IDLE with start=1, abort=0 and load_val!=0 SHALL, at the next edge, set count=load_val, latch load_val into an internal reload register and enter RUN (or PAUSED if pause=1).
REQ-015 IDLE with start=1 and load_val=0 SHALL, at the next edge, pulse done=1 for one cycle, hold count=0 and remain in IDLE.
REQ-016 start while busy=1 SHALL be ignored: no reload and no state change.
REQ-017 RUN with pause=0 SHALL decrement count by 1 per edge; latency rule: start accepted at edge N gives count=load_val-k after edge N+k.
REQ-018 RUN or PAUSED with pause=1 SHALL hold count and select PAUSED; pause=0 in PAUSED SHALL return to RUN, and decrementing resumes at that same edge.
REQ-019 When count=1 decrements, the edge SHALL set count=0 and done=1 for exactly one cycle.
REQ-020 In RUN with count=0, the next edge SHALL do one of the following:
- auto_reload=1: set count to the reload register and stay in RUN (period = reload+1 cycles);
- auto_reload=0: enter IDLE and hold count=0.
REQ-021 If pause=1 in the cycle count=1, no decrement SHALL occur and done SHALL stay 0; pause takes priority over reaching terminal.
REQ-022 abort=1 in any state SHALL, at the next edge, set count=0, enter IDLE, force done=0 and clear no other config.
REQ-023 abort SHALL take priority over start, pause and terminal in the same cycle.
REQ-024 The counter SHALL never wrap: a decrement below 0 SHALL be impossible in any state.
REQ-025 Arithmetic SHALL be unsigned WIDTH-bit; load_val=2^WIDTH-1 SHALL be legal (63 for default).
REQ-026 done SHALL never be high in two consecutive cycles, except with auto_reload and reload=0; that case is unreachable because a start with load_val=0 never enters RUN.

Reset
REQ-027 rst=1 at an edge SHALL force count=0, state IDLE, busy=0, ready=1, done=0 and reload register=0.
REQ-028 rst SHALL override abort, start and pause.
REQ-029 rst asserted mid-run SHALL abort the run with no done pulse.
REQ-030 Outputs SHALL be undefined-free from the first edge with rst=1.

Verification
REQ-031 The bench SHALL cover: rst high 2 cycles, start with load_val=5, pause=0 -> count 5,4,3,2,1,0 on successive edges; done=1 only in the count=0 cycle; then IDLE with ready=1.
REQ-032 The bench SHALL cover: load_val=3, auto_reload=1 -> count 3,2,1,0,3,2,1,0; done pulses every 4 cycles; busy stays 1.
REQ-033 The bench SHALL cover: load_val=4 with pause high 3 cycles when count=2 -> count holds 2 for 3 cycles in PAUSED, then 1,0; total 4+3 cycles to done.
REQ-034 The bench SHALL cover: load_val=10 with abort at count=6 -> count=0, IDLE next edge, no done; then start with load_val=0 -> single done pulse, count stays 0.
REQ-035 The bench SHALL cover: start re-asserted with load_val=9 while busy at count=4 -> ignored, and the run finishes 4,3,2,1,0.
REQ-036 The bench SHALL cover: rst asserted mid-run at count=7 with pause=1 and start=1 -> all outputs at reset values at the next edge.
